// File: rtl/cnn_frame_sequencer.sv
// Whole-frame controller: fetches pixels over a single-outstanding memory port,
// streams them to the line buffer and writes ReLU results back to memory.
module cnn_frame_sequencer #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned RES_WIDTH  = 32,
   parameter int unsigned IMG_W      = 28,
   parameter int unsigned IMG_H      = 28
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] input_base_i,
   input  logic [ADDR_WIDTH-1:0] output_base_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  mem_req_o,
   input  logic                  mem_gnt_i,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [31:0]           mem_wdata_o,
   input  logic                  mem_rvalid_i,
   input  logic [31:0]           mem_rdata_i,
   output logic                  pix_valid_o,
   input  logic                  pix_ready_i,
   output logic [DATA_WIDTH-1:0] pix_data_o,
   input  logic                  res_valid_i,
   output logic                  res_ready_o,
   input  logic [RES_WIDTH-1:0]  res_data_i
);

   localparam int unsigned NPIX = IMG_W * IMG_H;
   localparam int unsigned NRES = (IMG_W - 2) * (IMG_H - 2);
   localparam int unsigned CW   = $clog2(NPIX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ARB, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_DONE
   } state_e;

   state_e                r_state, w_state_d;
   logic [ADDR_WIDTH-1:0] r_in_base, w_in_base_d;
   logic [ADDR_WIDTH-1:0] r_out_base, w_out_base_d;
   logic [CW-1:0]         r_pix_cnt, w_pix_cnt_d;
   logic [CW-1:0]         r_acc_cnt, w_acc_cnt_d;
   logic [CW-1:0]         r_res_cnt, w_res_cnt_d;
   logic                  r_pix_full, w_pix_full_d;
   logic [DATA_WIDTH-1:0] r_pix_data, w_pix_data_d;
   logic                  r_res_full, w_res_full_d;
   logic [RES_WIDTH-1:0]  r_res_data, w_res_data_d;
   logic                  r_busy, w_busy_d;
   logic                  r_done, w_done_d;
   logic                  r_res_ready, w_res_ready_d;
   logic                  r_req, w_req_d;
   logic                  r_we, w_we_d;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
   logic [31:0]           r_wdata, w_wdata_d;
   logic                  w_pix_hs;
   logic                  w_res_hs;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_state_d;
   end

   // Next state, buffer/counter updates and next values of the registered outputs
   always_comb begin
      w_state_d     = r_state;
      w_in_base_d   = r_in_base;
      w_out_base_d  = r_out_base;
      w_pix_cnt_d   = r_pix_cnt;
      w_acc_cnt_d   = r_acc_cnt;
      w_res_cnt_d   = r_res_cnt;
      w_pix_full_d  = r_pix_full;
      w_pix_data_d  = r_pix_data;
      w_res_full_d  = r_res_full;
      w_res_data_d  = r_res_data;
      w_busy_d      = r_busy;
      w_done_d      = 1'b0;
      w_req_d       = 1'b0;
      w_we_d        = 1'b0;
      w_addr_d      = '0;
      w_wdata_d     = '0;
      w_res_ready_d = 1'b0;

      w_pix_hs = r_pix_full && pix_ready_i;
      w_res_hs = res_valid_i && r_res_ready;

      if (w_pix_hs) w_pix_full_d = 1'b0;
      if (w_res_hs) begin
         w_res_data_d = res_data_i;
         w_res_full_d = 1'b1;
         w_acc_cnt_d  = r_acc_cnt + CW'(1);
      end

      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_in_base_d  = input_base_i;
               w_out_base_d = output_base_i;
               w_pix_cnt_d  = '0;
               w_acc_cnt_d  = '0;
               w_res_cnt_d  = '0;
               w_busy_d     = 1'b1;
               w_state_d    = S_ARB;
            end
         end
         S_ARB: begin
            // Pending writes go first so the conv pipeline can always drain
            if (r_res_full) begin
               w_state_d = S_WR_REQ;
            end else if ((r_pix_cnt < CW'(NPIX)) && !r_pix_full) begin
               w_state_d = S_RD_REQ;
            end else if (r_res_cnt == CW'(NRES)) begin
               w_state_d = S_DONE;
               w_done_d  = 1'b1;
               w_busy_d  = 1'b0;
            end
         end
         S_RD_REQ: begin
            if (mem_gnt_i) w_state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (mem_rvalid_i) begin
               w_pix_full_d = 1'b1;
               w_pix_data_d = mem_rdata_i[DATA_WIDTH-1:0];
               w_pix_cnt_d  = r_pix_cnt + CW'(1);
               w_state_d    = S_ARB;
            end
         end
         S_WR_REQ: begin
            if (mem_gnt_i) w_state_d = S_WR_WAIT;
         end
         S_WR_WAIT: begin
            if (mem_rvalid_i) begin
               w_res_full_d = 1'b0;
               w_res_cnt_d  = r_res_cnt + CW'(1);
               w_state_d    = S_ARB;
            end
         end
         S_DONE: begin
            w_state_d = S_IDLE;
         end
         default: begin
            w_state_d = S_IDLE;
         end
      endcase

      // Bus outputs follow the next state; counters are frozen while a request waits
      if (w_state_d == S_RD_REQ) begin
         w_req_d  = 1'b1;
         w_addr_d = r_in_base + ADDR_WIDTH'({r_pix_cnt, 2'b00});
      end else if (w_state_d == S_WR_REQ) begin
         w_req_d   = 1'b1;
         w_we_d    = 1'b1;
         w_addr_d  = r_out_base + ADDR_WIDTH'({r_res_cnt, 2'b00});
         w_wdata_d = 32'($signed(r_res_data));
      end

      w_res_ready_d = w_busy_d && !w_res_full_d && (w_acc_cnt_d < CW'(NRES));
   end

   // Datapath and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_in_base   <= '0;
         r_out_base  <= '0;
         r_pix_cnt   <= '0;
         r_acc_cnt   <= '0;
         r_res_cnt   <= '0;
         r_pix_full  <= 1'b0;
         r_pix_data  <= '0;
         r_res_full  <= 1'b0;
         r_res_data  <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_res_ready <= 1'b0;
         r_req       <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
      end else begin
         r_in_base   <= w_in_base_d;
         r_out_base  <= w_out_base_d;
         r_pix_cnt   <= w_pix_cnt_d;
         r_acc_cnt   <= w_acc_cnt_d;
         r_res_cnt   <= w_res_cnt_d;
         r_pix_full  <= w_pix_full_d;
         r_pix_data  <= w_pix_data_d;
         r_res_full  <= w_res_full_d;
         r_res_data  <= w_res_data_d;
         r_busy      <= w_busy_d;
         r_done      <= w_done_d;
         r_res_ready <= w_res_ready_d;
         r_req       <= w_req_d;
         r_we        <= w_we_d;
         r_addr      <= w_addr_d;
         r_wdata     <= w_wdata_d;
      end
   end

   assign busy_o      = r_busy;
   assign done_o      = r_done;
   assign mem_req_o   = r_req;
   assign mem_we_o    = r_we;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_wdata;
   assign pix_valid_o = r_pix_full;
   assign pix_data_o  = r_pix_data;
   assign res_ready_o = r_res_ready;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Bench for cnn_frame_sequencer on a 4x4 frame: memory, line-buffer and ReLU
// models around the DUT, frame-level expectations derived from the address map.
`timescale 1ns/1ps
module tb_cnn_frame_sequencer;

   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 8;
   localparam int unsigned RW   = 16;
   localparam int unsigned IW   = 4;
   localparam int unsigned IH   = 4;
   localparam int unsigned NPIX = IW * IH;
   localparam int unsigned NRES = (IW - 2) * (IH - 2);

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          start_i;
   logic [AW-1:0] input_base_i, output_base_i;
   logic          busy_o, done_o;
   logic          mem_req_o, mem_gnt_i, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [31:0]   mem_wdata_o;
   logic          mem_rvalid_i;
   logic [31:0]   mem_rdata_i;
   logic          pix_valid_o, pix_ready_i;
   logic [DW-1:0] pix_data_o;
   logic          res_valid_i, res_ready_o;
   logic [RW-1:0] res_data_i;

   cnn_frame_sequencer #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RES_WIDTH(RW), .IMG_W(IW), .IMG_H(IH)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
      .input_base_i(input_base_i), .output_base_i(output_base_i),
      .busy_o(busy_o), .done_o(done_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i), .pix_data_o(pix_data_o),
      .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_data_i(res_data_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string       name;
      logic [31:0] in_base;
      logic [31:0] out_base;
      int          gnt_max;
      int          rv_max;
      bit          fixed_dly;
      int          rdy_pct;
      int          block;
      int          seq_off;
      int          extra;
      int          inject_at;
      logic [15:0] inject_val;
      bit          mid_start;
      bit          b2b;
      int          exp_reads;
      int          exp_writes;
      int          exp_dones;
   } vec_t;

   vec_t vecs[7];

   int n_checks = 0;
   int n_pass   = 0;

   // environment configuration
   logic [31:0] cfg_in_base;
   int          gnt_max, rv_max, rdy_pct, block_n, extra_res, inject_at;
   bit          fixed_dly;
   logic [15:0] inject_val;
   logic [7:0]  blk_data;
   logic [7:0]  mem_val [NPIX];

   // observation logs
   logic        txn_we    [$];
   logic [31:0] txn_addr  [$];
   logic [31:0] txn_wdata [$];
   logic [7:0]  pix_q     [$];
   logic [15:0] todo_q    [$];
   logic [15:0] off_q     [$];
   int          rd_at_acc [$];
   int          n_rd_logged, acc_n;
   bit          stab_err, ovl_err, bp_data_err, bp_req_err, ovr_err, res_flush;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Memory: single outstanding transaction, configurable grant/response delay
   initial begin : mem_proc
      logic [31:0] a, d, rnd;
      logic        w;
      int          gd, rd, idx;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      forever begin
         @(negedge clk_i);
         mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
         if (mem_req_o) begin
            a = mem_addr_o; w = mem_we_o; d = mem_wdata_o;
            txn_we.push_back(w); txn_addr.push_back(a); txn_wdata.push_back(d);
            if (!w) n_rd_logged++;
            gd = fixed_dly ? gnt_max : int'($urandom_range(gnt_max, 0));
            rd = fixed_dly ? rv_max  : int'($urandom_range(rv_max, 0));
            repeat (gd) begin
               @(negedge clk_i);
               if (!mem_req_o || mem_addr_o !== a || mem_we_o !== w || mem_wdata_o !== d)
                  stab_err = 1'b1;
            end
            mem_gnt_i = 1'b1;
            @(negedge clk_i);
            mem_gnt_i = 1'b0;
            if (mem_req_o) ovl_err = 1'b1;
            repeat (rd) begin
               @(negedge clk_i);
               if (mem_req_o) ovl_err = 1'b1;
            end
            idx = int'((a - cfg_in_base) >> 2);
            rnd = $urandom();
            mem_rdata_i  = (!w && idx >= 0 && idx < int'(NPIX)) ? {rnd[31:8], mem_val[idx]} : rnd;
            mem_rvalid_i = 1'b1;
         end
      end
   end

   // Line buffer / conv model: consumes pixels, emits one result per full 3x3 window
   initial begin : pix_proc
      int k;
      pix_ready_i = 1'b0;
      forever begin
         @(negedge clk_i);
         if (block_n > 0 && pix_valid_o) begin
            pix_ready_i = 1'b0;
            block_n--;
            if (pix_data_o !== blk_data) bp_data_err = 1'b1;
            if (mem_req_o) bp_req_err = 1'b1;
         end else begin
            pix_ready_i = ($urandom_range(99, 0) < rdy_pct);
         end
         if (pix_valid_o && pix_ready_i) begin
            pix_q.push_back(pix_data_o);
            k = pix_q.size() - 1;
            if (k == inject_at) todo_q.push_back(inject_val);
            if ((k / IW) >= 2 && (k % IW) >= 2) todo_q.push_back(16'($urandom()));
            if (k == int'(NPIX) - 1)
               for (int e = 0; e < extra_res; e++) todo_q.push_back(16'($urandom()));
         end
      end
   end

   // ReLU result source: offers queued results one at a time
   initial begin : res_proc
      bit hs;
      hs = 1'b0; res_valid_i = 1'b0; res_data_i = '0;
      forever begin
         @(negedge clk_i);
         if (res_flush) begin
            res_valid_i = 1'b0; todo_q.delete(); hs = 1'b0; res_flush = 1'b0;
         end
         if (hs) res_valid_i = 1'b0;
         if (!res_valid_i && todo_q.size() > 0) begin
            res_data_i  = todo_q.pop_front();
            res_valid_i = 1'b1;
            off_q.push_back(res_data_i);
         end
         if (res_ready_o && acc_n >= int'(NRES)) ovr_err = 1'b1;
         hs = res_valid_i && res_ready_o;
         if (hs) begin
            rd_at_acc.push_back(n_rd_logged);
            acc_n++;
         end
      end
   end

   task automatic prep(input vec_t v);
      cfg_in_base = v.in_base; gnt_max = v.gnt_max; rv_max = v.rv_max;
      fixed_dly = v.fixed_dly; rdy_pct = v.rdy_pct; extra_res = v.extra;
      inject_at = v.inject_at; inject_val = v.inject_val;
      for (int i = 0; i < int'(NPIX); i++)
         mem_val[i] = (v.seq_off > 0) ? 8'(i + v.seq_off) : 8'($urandom());
      blk_data = mem_val[0];
      txn_we.delete(); txn_addr.delete(); txn_wdata.delete();
      pix_q.delete(); todo_q.delete(); off_q.delete(); rd_at_acc.delete();
      n_rd_logged = 0; acc_n = 0;
      stab_err = 0; ovl_err = 0; bp_data_err = 0; bp_req_err = 0; ovr_err = 0;
      block_n = v.block;
      input_base_i = v.in_base; output_base_i = v.out_base;
   endtask

   task automatic run_frame(input vec_t v);
      int          cyc, dones, rd_i, wr_i;
      bit          busy_ok, busy_start;
      logic [15:0] od;
      @(negedge clk_i);
      prep(v);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      busy_start = busy_o;
      busy_ok = 1'b1; dones = 0; cyc = 0;
      while (cyc < 3000 && dones == 0) begin
         if (v.mid_start && cyc == 30) begin
            start_i = 1'b1; input_base_i = 32'hDEAD_0000; output_base_i = 32'hBEEF_0000;
         end else begin
            start_i = 1'b0;
         end
         @(negedge clk_i);
         cyc++;
         if (done_o) begin
            dones++;
            if (busy_o) busy_ok = 1'b0;
         end else if (!busy_o) begin
            busy_ok = 1'b0;
         end
      end
      start_i = 1'b0;
      if (!v.b2b) begin
         repeat (5) begin
            @(negedge clk_i);
            if (done_o) dones++;
            if (busy_o) busy_ok = 1'b0;
         end
         res_flush = 1'b1;
      end

      check({v.name, ":busy_after_start"}, 32'(busy_start), 32'd1);
      check({v.name, ":done_pulses"}, 32'(dones), 32'(v.exp_dones));
      check({v.name, ":busy_window"}, 32'(busy_ok), 32'd1);

      rd_i = 0; wr_i = 0;
      for (int t = 0; t < txn_we.size(); t++) begin
         if (!txn_we[t]) begin
            if (rd_i < int'(NPIX))
               check($sformatf("%s:rd_addr[%0d]", v.name, rd_i), txn_addr[t], v.in_base + 32'(4 * rd_i));
            rd_i++;
         end else begin
            if (wr_i < int'(NRES) && wr_i < off_q.size()) begin
               od = off_q[wr_i];
               check($sformatf("%s:wr_addr[%0d]", v.name, wr_i), txn_addr[t], v.out_base + 32'(4 * wr_i));
               check($sformatf("%s:wr_data[%0d]", v.name, wr_i), txn_wdata[t], {{16{od[15]}}, od});
               if (wr_i < rd_at_acc.size())
                  check($sformatf("%s:wr_before_rd[%0d]", v.name, wr_i),
                        32'(rd_i <= rd_at_acc[wr_i] + 1), 32'd1);
            end
            wr_i++;
         end
      end
      check({v.name, ":n_reads"}, 32'(rd_i), 32'(v.exp_reads));
      check({v.name, ":n_writes"}, 32'(wr_i), 32'(v.exp_writes));
      check({v.name, ":n_pixels"}, 32'(pix_q.size()), 32'(NPIX));
      for (int i = 0; i < pix_q.size() && i < int'(NPIX); i++)
         check($sformatf("%s:pixel[%0d]", v.name, i), 32'(pix_q[i]), 32'(mem_val[i]));
      check({v.name, ":req_stable"}, 32'(stab_err), 32'd0);
      check({v.name, ":one_outstanding"}, 32'(ovl_err), 32'd0);
      check({v.name, ":no_overrun"}, 32'(ovr_err), 32'd0);
      check({v.name, ":accepted"}, 32'(acc_n), 32'(NRES));
      if (v.block > 0) begin
         check({v.name, ":bp_data_hold"}, 32'(bp_data_err), 32'd0);
         check({v.name, ":bp_no_read"}, 32'(bp_req_err), 32'd0);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, ":busy"}, 32'(busy_o), 32'd0);
      check({tag, ":done"}, 32'(done_o), 32'd0);
      check({tag, ":req"}, 32'(mem_req_o), 32'd0);
      check({tag, ":we"}, 32'(mem_we_o), 32'd0);
      check({tag, ":addr"}, mem_addr_o, 32'd0);
      check({tag, ":wdata"}, mem_wdata_o, 32'd0);
      check({tag, ":pix_valid"}, 32'(pix_valid_o), 32'd0);
      check({tag, ":pix_data"}, 32'(pix_data_o), 32'd0);
      check({tag, ":res_ready"}, 32'(res_ready_o), 32'd0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : main
      int dones, busy_seen;
      rst_ni = 1'b0; start_i = 1'b0; input_base_i = '0; output_base_i = '0;
      gnt_max = 0; rv_max = 0; rdy_pct = 100; block_n = 0; extra_res = 0;
      inject_at = -1; inject_val = '0; fixed_dly = 1'b1; cfg_in_base = '0;
      res_flush = 1'b0; n_rd_logged = 0; acc_n = 0;

      //            name        in_base                   out_base                  g  r  fx rdy blk seq ex inj  ival      mid b2b rd wr dn
      vecs[0] = '{"small",      32'h0000_1000,            32'h0000_2000,            0, 0, 1, 100, 0, 1, 0, -1, 16'h0000, 0, 0, 16, 4, 1};
      vecs[1] = '{"stalls",     $urandom() & 32'hFFFC,    32'h0004_0000,            5, 3, 1, 100, 0, 0, 0, -1, 16'h0000, 0, 1, 16, 4, 1};
      vecs[2] = '{"random",     32'h8000_0100,            $urandom() & 32'hFFFF_FFFC, 4, 3, 0, 60, 0, 0, 0, -1, 16'h0000, 0, 0, 16, 4, 1};
      vecs[3] = '{"backpress",  32'h0000_3000,            32'h0000_4000,            0, 0, 1, 100, 10, 5, 0, -1, 16'h0000, 0, 0, 16, 4, 1};
      vecs[4] = '{"wr_prio",    32'h0000_5000,            32'h0000_6000,            2, 1, 0, 70, 0, 0, 0, 3, 16'hFFF9, 0, 0, 16, 4, 1};
      vecs[5] = '{"overrun",    32'h0000_7000,            32'h0000_8000,            1, 1, 0, 80, 0, 0, 1, -1, 16'h0000, 1, 0, 16, 4, 1};
      vecs[6] = '{"after_b2b",  32'h0000_9000,            32'h0000_A000,            0, 0, 1, 100, 0, 1, 0, -1, 16'h0000, 0, 0, 16, 4, 1};

      #12;
      check_outputs_zero("reset");
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);

      for (int i = 0; i < 7; i++) begin
         if (i == 2) begin
            // vector 1 ended without tail: re-run it back to back is covered by vector 2 start
         end
         run_frame(vecs[i]);
         if (!vecs[i].b2b) repeat (3) @(negedge clk_i);
      end

      // Reset in the middle of a frame
      @(negedge clk_i);
      prep(vecs[0]);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (25) @(negedge clk_i);
      busy_seen = busy_o;
      check("midreset:busy_before", 32'(busy_seen), 32'd1);
      @(posedge clk_i);
      #2 rst_ni = 1'b0;
      #1 check_outputs_zero("midreset");
      dones = 0;
      repeat (10) begin
         @(negedge clk_i);
         if (done_o) dones++;
      end
      rst_ni = 1'b1;
      res_flush = 1'b1;
      repeat (10) begin
         @(negedge clk_i);
         if (done_o) dones++;
      end
      check("midreset:no_done", 32'(dones), 32'd0);
      check("midreset:idle_busy", 32'(busy_o), 32'd0);
      vecs[0].name = "post_reset";
      run_frame(vecs[0]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
